// File: rtl/div_stream_ctrl.sv
// Stream sequencer in front of the iterative divider: accepts one operand pair,
// launches a single divide, captures the result (or a watchdog abort) and holds it
// until the downstream consumer takes it.
//
// state  | meaning
// IDLE   | ready for a new pair
// LAUNCH | one-cycle launch pulse to the divider, watchdog cleared
// WAIT   | divide in flight, watchdog running
// HOLD   | result (or timeout) presented until out_ready
module div_stream_ctrl #(
    parameter int DIVIDEND_WIDTH = 64,
    parameter int DIVISOR_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] in_dividend,
    input  logic [DIVISOR_WIDTH-1:0]  in_divisor,
    output logic                      div_valid_in,
    output logic [DIVIDEND_WIDTH-1:0] div_dividend,
    output logic [DIVISOR_WIDTH-1:0]  div_divisor,
    input  logic [DIVIDEND_WIDTH-1:0] div_quotient,
    input  logic [DIVISOR_WIDTH-1:0]  div_remainder,
    input  logic                      div_valid_out,
    input  logic                      div_overflow,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIVIDEND_WIDTH-1:0] out_quotient,
    output logic [DIVISOR_WIDTH-1:0]  out_remainder,
    output logic                      out_overflow,
    output logic                      out_timeout,
    output logic                      busy
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t                    state_q;
    logic [WD_W-1:0]           wdog_q;
    logic [WD_W-1:0]           wdog_d;
    logic                      div_valid_in_q;
    logic [DIVIDEND_WIDTH-1:0] div_dividend_q;
    logic [DIVISOR_WIDTH-1:0]  div_divisor_q;
    logic                      out_valid_q;
    logic [DIVIDEND_WIDTH-1:0] out_quotient_q;
    logic [DIVISOR_WIDTH-1:0]  out_remainder_q;
    logic                      out_overflow_q;
    logic                      out_timeout_q;

    // Saturating increment; the abort decision looks at the incremented value so the
    // timeout result appears TIMEOUT_CYCLES cycles after the launch pulse.
    always_comb begin
        wdog_d = wdog_q;
        if (wdog_q != WD_MAX) begin
            wdog_d = wdog_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            wdog_q          <= '0;
            div_valid_in_q  <= 1'b0;
            div_dividend_q  <= '0;
            div_divisor_q   <= '0;
            out_valid_q     <= 1'b0;
            out_quotient_q  <= '0;
            out_remainder_q <= '0;
            out_overflow_q  <= 1'b0;
            out_timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        div_dividend_q <= in_dividend;
                        div_divisor_q  <= in_divisor;
                        div_valid_in_q <= 1'b1;
                        state_q        <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    div_valid_in_q <= 1'b0;
                    wdog_q         <= '0;
                    state_q        <= ST_WAIT;
                end
                ST_WAIT: begin
                    wdog_q <= wdog_d;
                    if (div_valid_out) begin
                        out_quotient_q  <= div_quotient;
                        out_remainder_q <= div_remainder;
                        out_overflow_q  <= div_overflow;
                        out_timeout_q   <= 1'b0;
                        out_valid_q     <= 1'b1;
                        state_q         <= ST_HOLD;
                    end else if (wdog_d >= WD_LAST) begin
                        out_quotient_q  <= '0;
                        out_remainder_q <= '0;
                        out_overflow_q  <= 1'b0;
                        out_timeout_q   <= 1'b1;
                        out_valid_q     <= 1'b1;
                        state_q         <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    div_valid_in_q <= 1'b0;
                    out_valid_q    <= 1'b0;
                    state_q        <= ST_IDLE;
                end
            endcase
        end
    end

    // Decoded from the state register only, so ready is already high in IDLE after reset.
    assign in_ready      = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign div_valid_in  = div_valid_in_q;
    assign div_dividend  = div_dividend_q;
    assign div_divisor   = div_divisor_q;
    assign out_valid     = out_valid_q;
    assign out_quotient  = out_quotient_q;
    assign out_remainder = out_remainder_q;
    assign out_overflow  = out_overflow_q;
    assign out_timeout   = out_timeout_q;

endmodule

// File: tb/tb_div_stream_ctrl.sv
// Bench for div_stream_ctrl: a latency-programmable divider stub plus a schedule-based
// transaction model (launch / result / release cycles) checked on every negedge.
module tb_div_stream_ctrl;

    localparam int DW = 64;
    localparam int VW = 32;
    localparam int T  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_dividend = '0;
    logic [VW-1:0] in_divisor = '0;
    logic          div_valid_in;
    logic [DW-1:0] div_dividend;
    logic [VW-1:0] div_divisor;
    logic [DW-1:0] div_quotient = '0;
    logic [VW-1:0] div_remainder = '0;
    logic          div_valid_out = 1'b0;
    logic          div_overflow = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_quotient;
    logic [VW-1:0] out_remainder;
    logic          out_overflow;
    logic          out_timeout;
    logic          busy;

    div_stream_ctrl #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .div_valid_in(div_valid_in), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_valid_out(div_valid_out), .div_overflow(div_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quotient(out_quotient), .out_remainder(out_remainder),
        .out_overflow(out_overflow), .out_timeout(out_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Signed truncating divide as the real divider computes it; zero divisor flags overflow.
    function automatic void div_ref(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                    output logic [DW-1:0] q, output logic [VW-1:0] r,
                                    output logic ovf);
        longint sa, sb;
        sa = longint'(a);
        sb = longint'($signed(b));
        if (b == '0) begin
            q = '1; r = a[VW-1:0]; ovf = 1'b1;
        end else if (sb == -1) begin
            q = DW'(-sa); r = '0; ovf = 1'b0;
        end else begin
            q = DW'(sa / sb); r = VW'(sa % sb); ovf = 1'b0;
        end
    endfunction

    // Divider stub: cur_lat = cycles from the launch cycle to the result pulse, 0 = never.
    int            cur_lat = 0;
    int            dm_cnt = 0;
    logic [DW-1:0] dm_q;
    logic [VW-1:0] dm_r;
    logic          dm_o;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            dm_cnt <= 0;
            div_valid_out <= 1'b0;
        end else begin
            div_valid_out <= 1'b0;
            if (dm_cnt == 1 || (div_valid_in && cur_lat == 1)) begin
                div_ref(div_dividend, div_divisor, dm_q, dm_r, dm_o);
                div_quotient  <= dm_q;
                div_remainder <= dm_r;
                div_overflow  <= dm_o;
                div_valid_out <= 1'b1;
            end
            if (dm_cnt > 0) dm_cnt <= dm_cnt - 1;
            if (div_valid_in && cur_lat > 1) dm_cnt <= cur_lat - 1;
        end
    end

    // Transaction schedule model: launch interval, first result interval, last HOLD interval.
    int            m_L = 1000000;
    int            m_tout = 1000000;
    int            m_tend = -1;
    logic [DW-1:0] m_a, m_q;
    logic [VW-1:0] m_b, m_r;
    logic          m_ovf, m_to;

    always @(negedge clk) begin
        automatic logic e_busy = (cyc >= m_L) && (cyc <= m_tend);
        automatic logic e_ov   = (cyc >= m_tout) && (cyc <= m_tend);
        chk("div_valid_in", div_valid_in, (cyc == m_L) && e_busy);
        chk("busy", busy, e_busy);
        chk("in_ready", in_ready, !e_busy);
        chk("out_valid", out_valid, e_ov);
        if (e_busy) begin
            chk("div_dividend", div_dividend, m_a);
            chk("div_divisor", div_divisor, m_b);
        end
        if (e_ov) begin
            chk("out_quotient", out_quotient, m_q);
            chk("out_remainder", out_remainder, m_r);
            chk("out_overflow", out_overflow, m_ovf);
            chk("out_timeout", out_timeout, m_to);
        end
    end

    logic [DW-1:0] last_q;
    logic [VW-1:0] last_r;
    logic          last_ovf, last_to;
    int            launch_obs, first_ov;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pair(input logic [DW-1:0] a, input logic [VW-1:0] b,
                              input int lat, input int hold);
        int eff;
        div_ref(a, b, m_q, m_r, m_ovf);
        m_to = 1'b0;
        eff = lat;
        if (lat == 0 || lat > T - 1) begin
            m_q = '0; m_r = '0; m_ovf = 1'b0; m_to = 1'b1;
            eff = T - 1;
        end
        m_a = a;
        m_b = b;
        cur_lat = lat;
        in_valid = 1'b1;
        in_dividend = a;
        in_divisor = b;
        m_tend = cyc + 1 + eff + 1 + hold;
        m_tout = cyc + 1 + eff + 1;
        m_L = cyc + 1;
        tick();
    endtask

    task automatic run_pair(input logic [DW-1:0] a, input logic [VW-1:0] b,
                            input int lat, input int hold, input int gap);
        repeat (gap) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        out_ready = 1'b0;
        start_pair(a, b, lat, hold);
        launch_obs = -1;
        first_ov = -1;
        while (cyc <= m_tend) begin
            if (div_valid_in && launch_obs < 0) launch_obs = cyc;
            if (out_valid && first_ov < 0) begin
                first_ov = cyc;
                last_q = out_quotient; last_r = out_remainder;
                last_ovf = out_overflow; last_to = out_timeout;
            end
            in_valid = 1'($urandom_range(0, 1));
            in_dividend = {$urandom, $urandom};
            in_divisor = $urandom;
            if (cyc < m_tout) out_ready = 1'($urandom_range(0, 1));
            else out_ready = (cyc == m_tend);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        // Let any late divider pulse land while the block is idle.
        while (lat != 0 && cyc <= m_L + lat + 1) tick();
    endtask

    initial begin
        logic [DW-1:0] ra;
        logic [VW-1:0] rb;
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_div_valid_in", div_valid_in, 1'b0);
        chk("rst_div_dividend", div_dividend, 64'd0);
        chk("rst_div_divisor", div_divisor, 64'd0);
        chk("rst_out_quotient", out_quotient, 64'd0);
        chk("rst_out_timeout", out_timeout, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        reset = 1'b0;
        tick();

        run_pair(64'd100, 32'd7, 5, 0, 1);
        chk("lit_100_7_q", last_q, 64'd14);
        chk("lit_100_7_r", last_r, 64'd2);
        chk("lit_100_7_ovf", last_ovf, 1'b0);
        chk("lit_100_7_to", last_to, 1'b0);
        chk("lit_100_7_latency", first_ov - launch_obs, 64'd6);

        run_pair(-64'sd100, 32'd7, 9, 2, 2);
        chk("lit_m100_7_q", last_q, 64'hFFFF_FFFF_FFFF_FFF2);
        chk("lit_m100_7_r", last_r, 64'h0000_0000_FFFF_FFFE);

        run_pair(64'd55, 32'd0, 3, 1, 0);
        chk("lit_div0_ovf", last_ovf, 1'b1);
        chk("lit_div0_idle", in_ready, 1'b1);

        run_pair(64'd1234, 32'd10, 4, 20, 1);
        chk("lit_hold20_q", last_q, 64'd123);

        run_pair(64'd77, 32'd5, 0, 3, 1);
        chk("lit_timeout_to", last_to, 1'b1);
        chk("lit_timeout_q", last_q, 64'd0);
        chk("lit_timeout_latency", first_ov - launch_obs, 64'd16);

        run_pair(64'd40, 32'd8, T - 1, 0, 1);
        chk("lit_tie_to", last_to, 1'b0);
        chk("lit_tie_q", last_q, 64'd5);

        run_pair(64'd40, 32'd8, T + 2, 4, 1);
        chk("lit_late_to", last_to, 1'b1);

        start_pair(64'd500, 32'd3, 0, 0);
        repeat (5) tick();
        m_tend = cyc - 1;
        reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_div_valid_in", div_valid_in, 1'b0);
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        run_pair(64'd9, 32'd3, 2, 0, 1);
        chk("lit_after_rst_q", last_q, 64'd3);

        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) ra = DW'($signed(ra[15:0]));
            case ($urandom_range(0, 4))
                0:       rb = '0;
                1, 2:    rb = VW'($signed(5'($urandom)));
                default: rb = $urandom;
            endcase
            run_pair(ra, rb, $urandom_range(0, 20), $urandom_range(0, 5), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "bench time limit");
    end

endmodule
